ram16k_bist: RTL

Built-in self-test engine that drives the same interface the RAM16K exposes: `in`, `address`, `load` and `out`. It runs a four-element March test over the whole array, writing a background pattern and its complement, and checks every read. It sits between the RAM16K and the test/boot control logic. It reports pass/fail with the first failing address and the data read back there.

---
 rtl/ram16k_bist_pkg.sv | 21 ++
 rtl/bist_addr_counter.sv | 38 +++
 rtl/ram16k_bist.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ram16k_bist_pkg.sv
// Shared definitions for the March-test BIST engine: FSM state encodings and
// element direction constants.
package ram16k_bist_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StM0   = 3'd1,
        StM1   = 3'd2,
        StM2   = 3'd3,
        StM3   = 3'd4,
        StDone = 3'd5
    } state_e;

    localparam logic DirUp   = 1'b0;
    localparam logic DirDown = 1'b1;

    function automatic logic is_march(input state_e s);
        return (s == StM0) || (s == StM1) || (s == StM2) || (s == StM3);
    endfunction

endpackage

// File: rtl/bist_addr_counter.sv
// Address counter for the March elements: counts up or down one step per enable,
// loads 0 or DEPTH-1, and flags the last address of the current direction.
module bist_addr_counter
    import ram16k_bist_pkg::*;
#(
    parameter int AW    = 14,
    parameter int DEPTH = 16384
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_dir,
    input  logic          i_load_zero,
    input  logic          i_load_max,
    output logic [AW-1:0] o_count,
    output logic          o_at_end
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    logic [AW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load_zero) begin
            r_count <= '0;
        end else if (i_load_max) begin
            r_count <= LastAddr;
        end else if (i_en) begin
            r_count <= (i_dir == DirUp) ? r_count + AW'(1) : r_count - AW'(1);
        end
    end

    assign o_count  = r_count;
    assign o_at_end = (i_dir == DirUp) ? (r_count == LastAddr) : (r_count == '0);

endmodule

// File: rtl/ram16k_bist.sv
// March BIST engine for the RAM16K: four elements (w P; r P w ~P; r ~P w P; r P),
// reporting pass or the first failing address and the data read there.
module ram16k_bist
    import ram16k_bist_pkg::*;
#(
    parameter int W     = 16,
    parameter int AW    = 14,
    parameter int DEPTH = 16384
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [W-1:0]  i_pattern,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_pass,
    output logic          o_fail,
    output logic [AW-1:0] o_fail_addr,
    output logic [W-1:0]  o_fail_data,
    output logic [W-1:0]  o_ram_in,
    output logic [AW-1:0] o_ram_address,
    output logic          o_ram_load,
    input  logic [W-1:0]  i_ram_out
);

    state_e        r_state;
    state_e        w_state_d;
    logic [W-1:0]  r_pattern;
    logic          r_pass;
    logic          r_fail;
    logic [AW-1:0] r_fail_addr;
    logic [W-1:0]  r_fail_data;

    logic [AW-1:0] w_addr;
    logic          w_at_end;
    logic          w_dir;
    logic          w_cnt_en;
    logic          w_ld_zero;
    logic          w_ld_max;
    logic          w_check;
    logic          w_mismatch;
    logic [W-1:0]  w_expect;
    logic          w_accept;

    bist_addr_counter #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_cnt_en),
        .i_dir       (w_dir),
        .i_load_zero (w_ld_zero),
        .i_load_max  (w_ld_max),
        .o_count     (w_addr),
        .o_at_end    (w_at_end)
    );

    assign w_accept = (r_state == StIdle) && i_start;

    // Direction and read expectation of the running element.
    always_comb begin
        w_dir    = DirUp;
        w_expect = r_pattern;
        w_check  = 1'b0;
        case (r_state)
            StM1: w_check = 1'b1;
            StM2: begin
                w_dir    = DirDown;
                w_expect = ~r_pattern;
                w_check  = 1'b1;
            end
            StM3: begin
                w_dir   = DirDown;
                w_check = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_mismatch = w_check && (i_ram_out != w_expect);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_en  = 1'b0;
        w_ld_zero = 1'b0;
        w_ld_max  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StM0;
                    w_ld_zero = 1'b1;
                end
            end
            StM0: begin
                if (w_at_end) begin
                    w_state_d = StM1;
                    w_ld_zero = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            StM1, StM2: begin
                if (w_mismatch) begin
                    w_state_d = StDone;
                end else if (w_at_end) begin
                    w_state_d = (r_state == StM1) ? StM2 : StM3;
                    w_ld_max  = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            StM3: begin
                if (w_mismatch || w_at_end) begin
                    w_state_d = StDone;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Only the first mismatch is recorded: the FSM leaves the check states on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern   <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_accept) begin
            r_pattern   <= i_pattern;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_mismatch) begin
            r_fail      <= 1'b1;
            r_fail_addr <= w_addr;
            r_fail_data <= i_ram_out;
        end else if ((r_state == StM3) && w_at_end) begin
            r_pass <= 1'b1;
        end
    end

    always_comb begin
        o_ram_in   = '0;
        o_ram_load = 1'b0;
        case (r_state)
            StM0, StM2: begin
                o_ram_in   = r_pattern;
                o_ram_load = 1'b1;
            end
            StM1: begin
                o_ram_in   = ~r_pattern;
                o_ram_load = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_busy        = is_march(r_state);
    assign o_done        = (r_state == StDone);
    assign o_pass        = r_pass;
    assign o_fail        = r_fail;
    assign o_fail_addr   = r_fail_addr;
    assign o_fail_data   = r_fail_data;
    assign o_ram_address = w_addr;

endmodule
